// File: rtl/tetris_input_ctrl.sv
// Player-input front end: joystick direction FSM with hysteresis and DAS/ARR repeat,
// debounced pushbuttons with press pulses, and an all-buttons-held combo detector.

module tetris_btn_lane #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_press
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          r_s1, r_s2;
    logic [DW-1:0] r_cnt;
    logic          r_level, r_press;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
            if (r_s2 != r_level) begin
                if (r_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                    r_level <= r_s2;
                    r_press <= r_s2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt   <= r_cnt + DW'(1);
                    r_press <= 1'b0;
                end
            end else begin
                r_cnt   <= '0;
                r_press <= 1'b0;
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;
endmodule

module tetris_input_ctrl #(
    parameter int ADC_W           = 12,
    parameter int NUM_BTN         = 2,
    parameter int LEFT_THRESH     = 1550,
    parameter int RIGHT_THRESH    = 1750,
    parameter int HYST            = 50,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DAS_DELAY       = 8000000,
    parameter int ARR_PERIOD      = 2500000,
    parameter int COMBO_CYCLES    = 50000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [ADC_W-1:0]   adc_value,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic               move_left,
    output logic               move_right,
    output logic               dir_left,
    output logic               dir_right,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic               combo_hold
);
    localparam int REP_MAX = (DAS_DELAY > ARR_PERIOD) ? DAS_DELAY : ARR_PERIOD;
    localparam int RW      = $clog2(REP_MAX + 1);
    localparam int CW      = $clog2(COMBO_CYCLES + 1);

    localparam logic [ADC_W-1:0] L_TH  = ADC_W'(LEFT_THRESH);
    localparam logic [ADC_W-1:0] R_TH  = ADC_W'(RIGHT_THRESH);
    localparam logic [ADC_W-1:0] L_REL = ADC_W'(LEFT_THRESH + HYST);
    localparam logic [ADC_W-1:0] R_REL = ADC_W'(RIGHT_THRESH - HYST);

    typedef enum logic [1:0] {ST_CENTER, ST_LEFT, ST_RIGHT} state_t;

    state_t           r_state, w_state_nxt;
    logic [ADC_W-1:0] r_adc_q;
    logic             r_adc_vld;
    logic [RW-1:0]    r_rep, w_rep_nxt;
    logic             r_das_done, w_das_nxt;
    logic             r_ml, r_mr, w_ml_nxt, w_mr_nxt;
    logic             r_dir_l, r_dir_r;
    logic             w_hit;

    // r_adc_vld keeps the post-reset zero in adc_q from looking like a hard-left deflection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_adc_q    <= '0;
            r_adc_vld  <= 1'b0;
            r_state    <= ST_CENTER;
            r_rep      <= '0;
            r_das_done <= 1'b0;
            r_ml       <= 1'b0;
            r_mr       <= 1'b0;
            r_dir_l    <= 1'b0;
            r_dir_r    <= 1'b0;
        end else begin
            r_adc_q    <= adc_value;
            r_adc_vld  <= 1'b1;
            r_state    <= w_state_nxt;
            r_rep      <= w_rep_nxt;
            r_das_done <= w_das_nxt;
            r_ml       <= w_ml_nxt;
            r_mr       <= w_mr_nxt;
            r_dir_l    <= (w_state_nxt == ST_LEFT);
            r_dir_r    <= (w_state_nxt == ST_RIGHT);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!enable || !r_adc_vld) begin
            w_state_nxt = ST_CENTER;
        end else begin
            case (r_state)
                ST_CENTER: begin
                    if (r_adc_q < L_TH)       w_state_nxt = ST_LEFT;
                    else if (r_adc_q > R_TH)  w_state_nxt = ST_RIGHT;
                end
                ST_LEFT: begin
                    if (r_adc_q > R_TH)        w_state_nxt = ST_RIGHT;
                    else if (r_adc_q >= L_REL) w_state_nxt = ST_CENTER;
                end
                ST_RIGHT: begin
                    if (r_adc_q < L_TH)        w_state_nxt = ST_LEFT;
                    else if (r_adc_q <= R_REL) w_state_nxt = ST_CENTER;
                end
                default: w_state_nxt = ST_CENTER;
            endcase
        end
    end

    // Repeat counter runs to DAS once, then cycles on ARR; it resets at each pulse so never wraps.
    assign w_hit = r_das_done ? (r_rep == RW'(ARR_PERIOD - 1)) : (r_rep == RW'(DAS_DELAY - 1));

    always_comb begin
        w_ml_nxt  = 1'b0;
        w_mr_nxt  = 1'b0;
        w_rep_nxt = '0;
        w_das_nxt = 1'b0;
        if (w_state_nxt != ST_CENTER) begin
            if (w_state_nxt != r_state) begin
                w_ml_nxt = (w_state_nxt == ST_LEFT);
                w_mr_nxt = (w_state_nxt == ST_RIGHT);
            end else if (w_hit) begin
                w_ml_nxt  = (w_state_nxt == ST_LEFT);
                w_mr_nxt  = (w_state_nxt == ST_RIGHT);
                w_das_nxt = 1'b1;
            end else begin
                w_rep_nxt = r_rep + RW'(1);
                w_das_nxt = r_das_done;
            end
        end
    end

    assign move_left  = r_ml;
    assign move_right = r_mr;
    assign dir_left   = r_dir_l;
    assign dir_right  = r_dir_r;

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : gen_btn
        tetris_btn_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .i_raw  (btn_raw[gi]),
            .o_level(btn_level[gi]),
            .o_press(btn_press[gi])
        );
    end

    logic [CW-1:0] r_ccnt;
    logic          r_combo;
    logic          w_all;

    assign w_all = &btn_level;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ccnt  <= '0;
            r_combo <= 1'b0;
        end else if (w_all) begin
            if (r_ccnt != CW'(COMBO_CYCLES)) r_ccnt <= r_ccnt + CW'(1);
            if (r_ccnt == CW'(COMBO_CYCLES - 1)) r_combo <= 1'b1;
        end else begin
            r_ccnt  <= '0;
            r_combo <= 1'b0;
        end
    end

    assign combo_hold = r_combo;
endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Directed bench for tetris_input_ctrl with short debounce/DAS/ARR/combo timings.

module tb_tetris_input_ctrl;
    logic        clk = 1'b0;
    logic        reset, enable;
    logic [11:0] adc_value;
    logic [1:0]  btn_raw;
    logic        move_left, move_right, dir_left, dir_right, combo_hold;
    logic [1:0]  btn_level, btn_press;

    int errors = 0, checks = 0;
    int ml_n = 0, mr_n = 0, pr0_n = 0, ovl_n = 0;
    int snap;

    tetris_input_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .DAS_DELAY      (10),
        .ARR_PERIOD     (3),
        .COMBO_CYCLES   (20)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .adc_value (adc_value),
        .btn_raw   (btn_raw),
        .move_left (move_left),
        .move_right(move_right),
        .dir_left  (dir_left),
        .dir_right (dir_right),
        .btn_level (btn_level),
        .btn_press (btn_press),
        .combo_hold(combo_hold)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (move_left)  ml_n++;
        if (move_right) mr_n++;
        if (btn_press[0]) pr0_n++;
        if (move_left && move_right) ovl_n++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; adc_value = 12'd1650; btn_raw = 2'b00;
        tick(2);
        chk("rst_ml", move_left, 0);
        chk("rst_mr", move_right, 0);
        chk("rst_dl", dir_left, 0);
        chk("rst_dr", dir_right, 0);
        chk("rst_lvl", btn_level, 0);
        chk("rst_prs", btn_press, 0);
        chk("rst_combo", combo_hold, 0);
        reset = 1'b0;
        tick(3);
        chk("center_dl", dir_left, 0);
        chk("center_dr", dir_right, 0);

        // hysteresis
        snap = ml_n;
        adc_value = 12'd1500;
        tick(2);
        chk("hy_enter_dl", dir_left, 1);
        chk("hy_enter_ml", move_left, 1);
        tick(1);
        chk("hy_ml_1cyc", move_left, 0);
        tick(1);
        adc_value = 12'd1580;
        tick(3);
        chk("hy_hold_1580", dir_left, 1);
        adc_value = 12'd1600;
        tick(2);
        chk("hy_release", dir_left, 0);
        tick(2);
        chk("hy_one_pulse", ml_n - snap, 1);

        // auto-repeat
        adc_value = 12'd1800;
        tick(2);
        chk("ar_entry_mr", move_right, 1);
        chk("ar_entry_dr", dir_right, 1);
        for (int k = 1; k <= 40; k++) begin
            tick(1);
            chk($sformatf("ar_k%0d", k), move_right,
                (k >= 10 && k <= 28 && ((k - 10) % 3) == 0) ? 1 : 0);
            if (k == 28) adc_value = 12'd1600;
            if (k == 30) chk("ar_release_dr", dir_right, 0);
        end

        // direct swap right -> left
        adc_value = 12'd1800;
        tick(4);
        adc_value = 12'd1400;
        tick(1);
        chk("sw_still_right", dir_right, 1);
        tick(1);
        chk("sw_ml", move_left, 1);
        chk("sw_mr", move_right, 0);
        chk("sw_dl", dir_left, 1);
        chk("sw_dr", dir_right, 0);
        adc_value = 12'd1650;
        tick(3);
        chk("sw_back_center", dir_left, 0);

        // debounce: short glitch then real press
        snap = pr0_n;
        btn_raw = 2'b01;
        tick(3);
        btn_raw = 2'b00;
        tick(8);
        chk("db_glitch_lvl", btn_level, 0);
        chk("db_glitch_prs", pr0_n - snap, 0);
        btn_raw = 2'b01;
        tick(5);
        chk("db_lvl_early", btn_level[0], 0);
        tick(1);
        chk("db_lvl", btn_level[0], 1);
        chk("db_prs", btn_press[0], 1);
        tick(1);
        chk("db_prs_1cyc", btn_press[0], 0);
        chk("db_lvl_hold", btn_level[0], 1);
        tick(3);
        btn_raw = 2'b00;
        tick(8);
        chk("db_fall_lvl", btn_level[0], 0);
        chk("db_one_press", pr0_n - snap, 1);

        // combo
        btn_raw = 2'b11;
        tick(6);
        chk("cb_lvl", btn_level, 2'b11);
        chk("cb_prs", btn_press, 2'b11);
        tick(19);
        chk("cb_not_yet", combo_hold, 0);
        tick(1);
        chk("cb_hold", combo_hold, 1);
        btn_raw = 2'b01;
        tick(6);
        chk("cb_drop_lvl", btn_level, 2'b01);
        chk("cb_still", combo_hold, 1);
        tick(1);
        chk("cb_clear", combo_hold, 0);
        btn_raw = 2'b00;
        tick(8);

        // enable gating
        enable = 1'b0;
        adc_value = 12'd1400;
        snap = ml_n;
        tick(5);
        chk("en_off_dl", dir_left, 0);
        chk("en_off_ml", move_left, 0);
        chk("en_off_cnt", ml_n - snap, 0);
        enable = 1'b1;
        tick(1);
        chk("en_on_ml", move_left, 1);
        chk("en_on_dl", dir_left, 1);

        // reset in the middle of a right hold, button held through reset
        adc_value = 12'd1800;
        tick(2);
        chk("rr_entry", move_right, 1);
        tick(5);
        reset = 1'b1;
        btn_raw = 2'b01;
        #1;
        chk("rr_dr", dir_right, 0);
        chk("rr_mr", move_right, 0);
        chk("rr_dl", dir_left, 0);
        chk("rr_lvl", btn_level, 0);
        tick(2);
        reset = 1'b0;
        tick(1);
        chk("rr_no_pulse", move_right | move_left, 0);
        chk("rr_dr_wait", dir_right, 0);
        tick(1);
        chk("rr_reentry_mr", move_right, 1);
        chk("rr_reentry_dr", dir_right, 1);
        tick(4);
        chk("rr_btn_prs", btn_press, 2'b01);
        chk("rr_btn_lvl", btn_level, 2'b01);

        tick(2);
        chk("no_overlap", ovl_n, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tetris_input_ctrl.md
# tetris_input_ctrl

Parametrised player-input front end for the Tetris design. It sits between the raw ADC joystick result and pushbuttons and the game logic (`tetris_grid`). It converts the joystick reading into left/right direction states with hysteresis. Held directions produce single-cycle move pulses with delayed auto-repeat (DAS/ARR). It also debounces N pushbuttons into levels and press pulses, and detects a timed all-buttons-held combo for game reset.

## Interface
- `ADC_W`, 12: ADC result width.
- `NUM_BTN`, 2: pushbutton count (≥1).
- `LEFT_THRESH`, 1550: enter LEFT when `adc_value < LEFT_THRESH`.
- `RIGHT_THRESH`, 1750: enter RIGHT when `adc_value > RIGHT_THRESH`.
- `HYST`, 50: release margin (must satisfy `LEFT_THRESH + HYST ≤ RIGHT_THRESH - HYST`).
- `DEBOUNCE_CYCLES`, 500000: stable cycles needed to accept a button change (≥1).
- `DAS_DELAY`, 8000000: cycles from initial move pulse to first repeat (≥1).
- `ARR_PERIOD`, 2500000: cycles between subsequent repeats (≥1).
- `COMBO_CYCLES`, 50000000: all-buttons-held time before `combo_hold` asserts (≥1).

Ports:
- `clk` in 1: single clock; all state on its rising edge.
- `reset` in 1: asynchronous, active-high. Clears all state.
- `enable` in 1: high enables direction tracking and move pulses.
- `adc_value` in ADC_W: unsigned joystick X reading.
- `btn_raw` in NUM_BTN: asynchronous active-high buttons.
- `move_left` out 1: one-cycle move pulse.
- `move_right` out 1: one-cycle move pulse.
- `dir_left` out 1: level, FSM in LEFT.
- `dir_right` out 1: level, FSM in RIGHT.
- `btn_level` out NUM_BTN: debounced button state.
- `btn_press` out NUM_BTN: one-cycle pulse on each debounced rising edge.
- `combo_hold` out 1: level, all buttons held ≥ COMBO_CYCLES.

## Operation
- All outputs are registered. Every output and counter resets to 0, and the FSM resets to CENTER.
- `adc_value` is registered into `adc_q` each cycle. The FSM acts on `adc_q`.
- Direction FSM states are CENTER, LEFT and RIGHT.
  - CENTER→LEFT if `adc_q < LEFT_THRESH`. CENTER→RIGHT if `adc_q > RIGHT_THRESH`.
  - LEFT→RIGHT if `adc_q > RIGHT_THRESH`. Otherwise LEFT→CENTER if `adc_q ≥ LEFT_THRESH + HYST`.
  - RIGHT→LEFT if `adc_q < LEFT_THRESH`. Otherwise RIGHT→CENTER if `adc_q ≤ RIGHT_THRESH - HYST`.
  - Values between threshold and release point hold the current state.
- Every entry into LEFT or RIGHT (including a direct LEFT↔RIGHT swap) asserts the matching move pulse on the same edge and clears the repeat counter.
- Repeat counter behaviour while the FSM stays in a direction:
  - First repeat pulse comes DAS_DELAY cycles after the entry pulse.
  - Further pulses follow every ARR_PERIOD cycles.
  - The counter saturates/rolls within its own width and never wraps to a spurious pulse.
- `move_left` and `move_right` are never both high.
- `enable` low:
  - FSM is forced to CENTER, move pulses are 0 and the repeat counter is 0.
  - On return high, normal entry rules apply, so a joystick already deflected yields an entry pulse.
- Each button path:
  - 2-FF synchroniser produces `s`.
  - The debounce counter increments while `s != btn_level` and clears when they are equal.
  - When the counter would reach DEBOUNCE_CYCLES, `btn_level <= s` and the counter clears.
  - `btn_press[i]` is high for the one cycle in which `btn_level[i]` rises. There is no pulse on fall.
- Combo:
  - The counter increments while all `btn_level` bits are 1, and saturates.
  - `combo_hold` rises when the count reaches COMBO_CYCLES.
  - When any bit is 0, the counter and `combo_hold` clear on the next edge.
- Button logic is independent of `enable`.

## Timing
- Joystick latency: `adc_value` change seen at edge N is captured at N+1. `dir_*` and the entry pulse change at edge N+2.
- Repeat: with entry pulse at edge E, repeats occur at E+DAS_DELAY, then E+DAS_DELAY+k·ARR_PERIOD.
- Leaving a direction clears `dir_*` at the transition edge, and no further pulse is issued.
- Button latency: a raw edge stable from edge N gives `btn_level`/`btn_press` at edge N+2+DEBOUNCE_CYCLES. A glitch shorter than DEBOUNCE_CYCLES is ignored.
- Combo: `combo_hold` rises exactly COMBO_CYCLES edges after `&btn_level` first becomes 1.
- Async reset mid-operation clears outputs immediately, with no pulse on release. The synchroniser refills, so a button held through reset produces a press pulse after 2+DEBOUNCE_CYCLES cycles.

## Test plan
Parameter overrides for all scenarios: DEBOUNCE_CYCLES=4, DAS_DELAY=10, ARR_PERIOD=3, COMBO_CYCLES=20.

1. Hysteresis: `adc_value` sequence 1650→1500→1580→1600 (held ≥3 cycles each). Required: `dir_left` set at 1500, still set at 1580, cleared at 1600. Exactly one `move_left` pulse.
2. Auto-repeat: `adc_value`=1800 held for 30 cycles after entry pulse at E. Required: `move_right` pulses at E, E+10, E+13, …, E+28, then none after release to 1600.
3. Direct swap: 1800 then 1400. Required: `move_left` pulse 2 edges after the change, `dir_right`→0 on the same edge, and no overlapping pulses.
4. Debounce: 3-cycle high glitch on `btn_raw[0]`, then a 10-cycle press. Required: no output for the glitch. The press gives `btn_level[0]`/`btn_press[0]` at 6 edges after the rise, and the pulse is 1 cycle wide.
5. Combo and enable:
   - Both buttons held. Required: `combo_hold` at 20 edges after `btn_level`=11, and cleared 1 edge after `btn_level[1]` drops.
   - `enable`=0 with `adc_value`=1400. Required: no pulses. Entry pulse 1 edge after `enable` rises.
6. Reset mid-repeat: assert `reset` at E+5 during a RIGHT hold. Required: all outputs 0 immediately, and new entry pulse 2 edges after release.
